// File: rtl/painterengine_gpu_pkg.sv
// Shared types for the GPU DMA writer lanes: FSM state encoding, fill modes,
// and the per-word accumulator advance used by the fill source.
package painterengine_gpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } fill_state_e;

  localparam logic [1:0] FILL_SOLID = 2'd0;
  localparam logic [1:0] FILL_INC32 = 2'd1;
  localparam logic [1:0] FILL_INC8  = 2'd2;
  localparam logic [1:0] FILL_RSVD  = 2'd3;

  // Word k+1 from word k; INC8 adds each byte lane independently (no carries).
  function automatic logic [31:0] fill_advance(input logic [31:0] acc,
                                               input logic [31:0] step,
                                               input logic [1:0]  mode);
    logic [31:0] nxt;
    nxt = acc;
    case (mode)
      FILL_INC32: nxt = acc + step;
      FILL_INC8: begin
        for (int i = 0; i < 4; i++) nxt[8*i +: 8] = acc[8*i +: 8] + step[8*i +: 8];
      end
      default: nxt = acc;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/painterengine_gpu_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and synchronous flush.
// DEPTH must be a power of two so the pointers wrap for free.
module painterengine_gpu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_wire_clock,
  input  logic                     i_wire_resetn,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != FULL);
  assign do_pop  = pop_i && (count_q != '0);

  // NOTE: storage is reset too so the head word reads 0 out of reset rather than X.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/painterengine_gpu_fill_source.sv
// Solid / incrementing pattern generator for one GPU DMA writer data lane.
// Words are produced by a running accumulator and buffered in a show-ahead FIFO.
module painterengine_gpu_fill_source
  import painterengine_gpu_pkg::*;
#(
  parameter int PARAM_FIFO_DEPTH = 4
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic        i_wire_start,
  input  logic        i_wire_abort,
  input  logic [31:0] i_wire_length,
  input  logic [31:0] i_wire_color,
  input  logic [31:0] i_wire_step,
  input  logic [1:0]  i_wire_mode,
  output logic [31:0] o_wire_data,
  output logic        o_wire_data_valid,
  input  logic        i_wire_data_next,
  output logic        o_wire_busy,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [31:0] o_wire_count
);

  localparam int CW = $clog2(PARAM_FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(PARAM_FIFO_DEPTH);

  fill_state_e state_q, state_d;
  logic [31:0] length_q, length_d;
  logic [31:0] step_q, step_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] pushed_q, pushed_d;
  logic [31:0] count_q, count_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_valid, push, pop, flush, start_ok;

  assign start_ok = i_wire_start && (state_q != ST_RUN);
  assign pop      = i_wire_data_next && fifo_valid;
  // Space is judged on the registered count, so a same-cycle pop never enables a push.
  assign push     = (state_q == ST_RUN) && !i_wire_abort &&
                    (fifo_count < DEPTH_C) && (pushed_q < length_q);

  // NOTE: every next-state variable gets its hold value first, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    step_d   = step_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    pushed_d = pushed_q;
    count_d  = count_q;
    flush    = 1'b0;
    if (i_wire_abort) begin
      state_d = ST_IDLE;
      flush   = 1'b1;
    end else if (start_ok) begin
      length_d = i_wire_length;
      step_d   = i_wire_step;
      mode_d   = i_wire_mode;
      acc_d    = i_wire_color;
      pushed_d = '0;
      count_d  = '0;
      flush    = 1'b1;
      state_d  = (i_wire_mode == FILL_RSVD || i_wire_length == '0) ? ST_ERROR : ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (push) begin
        acc_d    = fill_advance(acc_q, step_q, mode_q);
        pushed_d = pushed_q + 32'd1;
      end
      if (pop) begin
        count_d = count_q + 32'd1;
        if (count_q + 32'd1 == length_q) state_d = ST_DONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q  <= ST_IDLE;
      length_q <= '0;
      step_q   <= '0;
      mode_q   <= FILL_SOLID;
      acc_q    <= '0;
      pushed_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      step_q   <= step_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      pushed_q <= pushed_d;
      count_q  <= count_d;
    end
  end

  painterengine_gpu_sync_fifo #(
    .WIDTH(32),
    .DEPTH(PARAM_FIFO_DEPTH)
  ) u_fifo (
    .i_wire_clock (i_wire_clock),
    .i_wire_resetn(i_wire_resetn),
    .flush_i      (flush),
    .push_i       (push),
    .data_i       (acc_q),
    .pop_i        (pop),
    .data_o       (o_wire_data),
    .valid_o      (fifo_valid),
    .count_o      (fifo_count)
  );

  assign o_wire_data_valid = fifo_valid;
  assign o_wire_busy       = (state_q == ST_RUN);
  assign o_wire_done       = (state_q == ST_DONE);
  assign o_wire_error      = (state_q == ST_ERROR);
  assign o_wire_count      = count_q;

endmodule

// File: tb/tb_painterengine_gpu_fill_source.sv
// Self-checking bench for the fill source: directed cases plus random runs
// scored against an arithmetic model of the fill word sequence.
module tb_painterengine_gpu_fill_source;

  localparam int DEPTH = 4;

  logic        clk, rstn;
  logic        start, abort, next;
  logic [31:0] length, color, step;
  logic [1:0]  mode;
  logic [31:0] data, count;
  logic        valid, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  painterengine_gpu_fill_source #(.PARAM_FIFO_DEPTH(DEPTH)) dut (
    .i_wire_clock     (clk),
    .i_wire_resetn    (rstn),
    .i_wire_start     (start),
    .i_wire_abort     (abort),
    .i_wire_length    (length),
    .i_wire_color     (color),
    .i_wire_step      (step),
    .i_wire_mode      (mode),
    .o_wire_data      (data),
    .o_wire_data_valid(valid),
    .i_wire_data_next (next),
    .o_wire_busy      (busy),
    .o_wire_done      (done),
    .o_wire_error     (err),
    .o_wire_count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Word k from first principles: k*step, per-byte in mode 2.
  function automatic logic [31:0] exp_word(input logic [31:0] c, input logic [31:0] s,
                                           input logic [1:0] m, input int k);
    logic [31:0] kk, w;
    logic [7:0]  k8, b;
    kk = k;
    k8 = kk[7:0];
    w  = c;
    if (m == 2'd1) w = c + s * kk;
    else if (m == 2'd2) begin
      for (int i = 0; i < 4; i++) begin
        b = c[8*i +: 8] + s[8*i +: 8] * k8;
        w[8*i +: 8] = b;
      end
    end
    return w;
  endfunction

  task automatic do_start(input logic [31:0] l, input logic [31:0] c,
                          input logic [31:0] s, input logic [1:0] m);
    @(negedge clk);
    length = l; color = c; step = s; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // period 1: pop every cycle, N>1: every Nth cycle, 0: random.
  task automatic run(input string nm, input logic [31:0] l, input logic [31:0] c,
                     input logic [31:0] s, input logic [1:0] m,
                     input int period, input int abort_after);
    int k = 0;
    int cyc = 0;
    bit fin = 0;
    do_start(l, c, s, m);
    check({nm, "_busy_t1"}, busy, 1);
    check({nm, "_valid_t1"}, valid, 0);
    while (!fin && cyc < 300) begin
      @(negedge clk);
      if (period == 1) check({nm, "_no_bubble"}, valid, 1);
      if (period == 0) next = 1'($urandom_range(0, 1));
      else             next = ((cyc % period) == 0);
      check({nm, "_fifo_le_depth"}, 32'(dut.u_fifo.count_o <= DEPTH), 1);
      if (valid && next) begin
        check({nm, "_count"}, count, k);
        check({nm, "_word"}, data, exp_word(c, s, m, k));
        k++;
      end
      cyc++;
      if (k == int'(l)) begin
        @(negedge clk);
        next = 1'b0;
        check({nm, "_done"}, done, 1);
        check({nm, "_final_count"}, count, l);
        check({nm, "_drained"}, valid, 0);
        fin = 1;
      end else if (abort_after > 0 && k == abort_after) begin
        @(negedge clk);
        next = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check({nm, "_abort_valid"}, valid, 0);
        check({nm, "_abort_idle"}, {busy, done, err}, 0);
        check({nm, "_abort_count"}, count, abort_after);
        fin = 1;
      end
    end
    next = 1'b0;
    if (!fin) check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_error(input string nm, input logic [31:0] l, input logic [1:0] m);
    do_start(l, 32'h1234_5678, 32'h1, m);
    check({nm, "_error"}, err, 1);
    check({nm, "_busy"}, busy, 0);
    next = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check({nm, "_no_valid"}, valid, 0);
      @(negedge clk);
    end
    next = 1'b0;
    check({nm, "_holds"}, err, 1);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; next = 1'b0;
    length = '0; color = '0; step = '0; mode = '0;
    #23 rstn = 1'b1;
    @(negedge clk);
    check("rst_outputs", {valid, busy, done, err}, 0);
    check("rst_count", count, 0);
    check("rst_data", data, 0);

    run("solid", 5, 32'hFF00FF00, 32'h0, 2'd0, 1, 0);
    run("inc32_wrap", 4, 32'hFFFFFFFE, 32'h1, 2'd1, 1, 0);
    run("inc8", 3, 32'h01FF80FE, 32'h01010101, 2'd2, 1, 0);
    check("inc8_const", exp_word(32'h01FF80FE, 32'h01010101, 2'd2, 2), 32'h03018200);
    run("slow", 10, 32'hA5A5_0000, 32'h0000_0101, 2'd1, 3, 0);
    run("abort", 8, 32'h10, 32'h10, 2'd1, 1, 3);
    run("after_abort", 4, 32'h10, 32'h10, 2'd1, 1, 0);

    run_error("len0", 0, 2'd1);
    run("recover_len0", 2, 32'h7, 32'h3, 2'd1, 1, 0);
    run_error("mode3", 6, 2'd3);
    run("recover_mode3", 3, 32'h7F7F7F7F, 32'h81818181, 2'd2, 2, 0);

    for (int r = 0; r < 8; r++)
      run("rand", 32'($urandom_range(1, 12)), $urandom, $urandom,
          2'($urandom_range(0, 2)), $urandom_range(0, 3), 0);

    // Asynchronous reset in the middle of a run, between clock edges.
    do_start(20, 32'h55, 32'h1, 2'd1);
    next = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_reset_count", 32'(count != 0), 1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_outputs", {valid, busy, done, err}, 0);
    check("async_rst_count", count, 0);
    check("async_rst_data", data, 0);
    next = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run("post_reset", 3, 32'hCAFE0000, 32'h2, 2'd1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
